// File: rtl/data_memory_arbiter_pkg.sv
// Shared constants for the data-RAM arbiter: FSM encodings and counter widths.
package data_memory_arbiter_pkg;

    localparam int unsigned STALL_CNT_W = 16;
    localparam int unsigned WAIT_CNT_W  = 8;

    localparam logic [1:0] ST_NORMAL  = 2'd0;
    localparam logic [1:0] ST_STARVE  = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    function automatic logic is_access(input logic read_en, input logic write_en);
        return read_en | write_en;
    endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Bundle of MEM-stage, auxiliary-requester and RAM-side signals around the arbiter.
interface data_memory_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  pipe_read_enable;
    logic                  pipe_write_enable;
    logic [ADDR_WIDTH-1:0] pipe_address;
    logic [DATA_WIDTH-1:0] pipe_write_data;
    logic [DATA_WIDTH-1:0] pipe_read_data;
    logic                  pipe_stall;

    logic                  aux_req;
    logic                  aux_we;
    logic [ADDR_WIDTH-1:0] aux_address;
    logic [DATA_WIDTH-1:0] aux_write_data;
    logic                  aux_gnt;
    logic [DATA_WIDTH-1:0] aux_rdata;
    logic                  aux_rvalid;

    logic                  ram_read_enable;
    logic                  ram_write_enable;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_in_data;
    logic [DATA_WIDTH-1:0] ram_out_data;

    // Arbiter side
    modport slave (
        input  pipe_read_enable, pipe_write_enable, pipe_address, pipe_write_data,
        output pipe_read_data, pipe_stall,
        input  aux_req, aux_we, aux_address, aux_write_data,
        output aux_gnt, aux_rdata, aux_rvalid,
        output ram_read_enable, ram_write_enable, ram_address, ram_in_data,
        input  ram_out_data
    );

    // Requesters plus RAM side
    modport master (
        output pipe_read_enable, pipe_write_enable, pipe_address, pipe_write_data,
        input  pipe_read_data, pipe_stall,
        output aux_req, aux_we, aux_address, aux_write_data,
        input  aux_gnt, aux_rdata, aux_rvalid,
        input  ram_read_enable, ram_write_enable, ram_address, ram_in_data,
        output ram_out_data
    );

endinterface

// File: rtl/data_memory_arbiter_sat_counter.sv
// Up-counter that sticks at all-ones; clear takes priority over increment.
module data_memory_arbiter_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data RAM between the MEM stage (priority) and an aux requester,
// forcing one aux access after MAX_WAIT blocked cycles at the cost of a pipeline stall.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    data_memory_arbiter_if.slave   bus,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic                  pipe_acc;
    logic                  pipe_gnt;
    logic                  aux_gnt;
    logic                  pipe_stall;
    logic                  wait_inc;
    logic                  wait_clr;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [DATA_WIDTH-1:0] aux_rdata_q;
    logic                  aux_rvalid_q;

    assign pipe_acc = is_access(bus.pipe_read_enable, bus.pipe_write_enable);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant selection, starvation tracking and next state
    always_comb begin
        state_d    = state_q;
        pipe_gnt   = 1'b0;
        aux_gnt    = 1'b0;
        pipe_stall = 1'b0;
        wait_inc   = 1'b0;
        wait_clr   = 1'b0;
        case (state_q)
            ST_STARVE: begin
                wait_clr = 1'b1;
                state_d  = ST_NORMAL;
                if (bus.aux_req) begin
                    aux_gnt    = 1'b1;
                    pipe_stall = pipe_acc;
                    if (pipe_acc) begin
                        state_d = ST_RECOVER;
                    end
                end else begin
                    pipe_gnt = pipe_acc;
                end
            end
            // The stalled MEM access retires here before aux can be forced again
            ST_RECOVER: begin
                pipe_gnt = pipe_acc;
                aux_gnt  = ~pipe_acc & bus.aux_req;
                wait_clr = 1'b1;
                state_d  = ST_NORMAL;
            end
            default: begin
                pipe_gnt = pipe_acc;
                aux_gnt  = ~pipe_acc & bus.aux_req;
                state_d  = ST_NORMAL;
                if (bus.aux_req && !aux_gnt) begin
                    wait_inc = 1'b1;
                    if (wait_cnt == WAIT_CNT_W'(MAX_WAIT - 1)) begin
                        state_d = ST_STARVE;
                    end
                end else begin
                    wait_clr = 1'b1;
                end
            end
        endcase
    end

    data_memory_arbiter_sat_counter #(.WIDTH(WAIT_CNT_W)) u_wait_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (wait_inc),
        .clear_i (wait_clr),
        .count_o (wait_cnt)
    );

    data_memory_arbiter_sat_counter #(.WIDTH(STALL_CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (pipe_stall),
        .clear_i (1'b0),
        .count_o (stall_count)
    );

    // RAM port steered by the winner; idle cycles drive zeros
    always_comb begin
        bus.ram_read_enable  = 1'b0;
        bus.ram_write_enable = 1'b0;
        bus.ram_address      = ADDR_WIDTH'(0);
        bus.ram_in_data      = DATA_WIDTH'(0);
        if (pipe_gnt) begin
            bus.ram_read_enable  = bus.pipe_read_enable;
            bus.ram_write_enable = bus.pipe_write_enable;
            bus.ram_address      = bus.pipe_address;
            bus.ram_in_data      = bus.pipe_write_data;
        end else if (aux_gnt) begin
            bus.ram_read_enable  = ~bus.aux_we;
            bus.ram_write_enable = bus.aux_we;
            bus.ram_address      = bus.aux_address;
            bus.ram_in_data      = bus.aux_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aux_rdata_q  <= '0;
            aux_rvalid_q <= 1'b0;
        end else begin
            aux_rvalid_q <= aux_gnt & ~bus.aux_we;
            if (aux_gnt && !bus.aux_we) begin
                aux_rdata_q <= bus.ram_out_data;
            end
        end
    end

    assign bus.pipe_read_data = bus.ram_out_data;
    assign bus.pipe_stall     = pipe_stall;
    assign bus.aux_gnt        = aux_gnt;
    assign bus.aux_rdata      = aux_rdata_q;
    assign bus.aux_rvalid     = aux_rvalid_q;

endmodule
